memory_spram_banked: RTL and testbench
======================================

# memory_spram_banked

Parametrised, power-managed successor to the single-region SPRAM memory: maps `NUM_BANKS` 32-bit SPRAM banks into one contiguous bus region. Each bank is built from two SB_SPRAM256KA primitives. An explicit access FSM gives deterministic `done` timing. Idle banks drop into retention standby automatically and are woken on demand. It sits on the CPU data bus beside the other address-decoded peripherals.

## Interface
- `BASE_ADDRESS`, 32'hF000_0000, byte address of word 0; must be 4-byte aligned.
- `NUM_BANKS`, 2, number of 32-bit banks; legal values 1 or 2 (iCE40UP5K).
- `BANK_WORDS`, 16384, words per bank; fixed by the primitive.
- `IDLE_CYCLES`, 64, consecutive idle cycles before a bank enters standby; 0 disables power management.
- `WAKE_CYCLES`, 3, cycles STANDBY must be low before a woken bank is accessed; ≥1.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 32: byte address; bits [1:0] ignored.
- `wdata` in 32: write data.
- `wmask` in 4: byte enables; bit i enables `wdata[8i+7:8i]`.
- `wen` in 1: write request; held with `addr`/`wdata`/`wmask` until `done`.
- `ren` in 1: read request; held with `addr` until `done`.
- `rdata` out 32: read data.
- `done` out 1: one-cycle completion pulse.
- `active` out 1: combinational; `addr` is inside this block's region.
- `bank_asleep` out NUM_BANKS: per-bank STANDBY state.

## Operation
- Region: `BASE_ADDRESS` to `BASE_ADDRESS + NUM_BANKS*BANK_WORDS*4 - 4` inclusive. `active` covers every bank, including the top word.
- Local word index = `(addr - BASE_ADDRESS) >> 2`.
  - Bank = index / `BANK_WORDS`.
  - SPRAM address = index mod `BANK_WORDS` (14 bits).
- MSB primitive: MASKWREN = {wmask[3],wmask[3],wmask[2],wmask[2]}. LSB primitive: same pattern from wmask[1:0].
- POWEROFF=1 and SLEEP=0 always. STANDBY driven from `bank_asleep`.
- A request is a cycle with `active & (ren | wen)`. If `wen` and `ren` are both high, the request is a write.
- Inactive addresses produce no state change and no `done`.
- FSM states:
  - IDLE: sample request. Target bank awake → drive CHIPSELECT, and WREN if a write, to that bank only; latch bank index; go RESP. Target bank asleep → clear its `bank_asleep`, load wake counter with `WAKE_CYCLES-1`; go WAKE.
  - WAKE: count down. At 0, drive the access as in IDLE; go RESP.
  - RESP: `done`=1. Read: `rdata` = DATAOUT of the latched bank. Go IDLE. No CHIPSELECT/WREN in this state.
- `rdata` holds its last read value until the next read completes; writes leave it unchanged.
- `wmask`=0 with `wen`: no memory change, `done` still pulses.
- Power management (`IDLE_CYCLES`>0): one idle counter per bank.
  - Counter clears on any access to that bank and saturates at `IDLE_CYCLES`.
  - At saturation, in any FSM state other than WAKE-for-that-bank, `bank_asleep`[b] is set.
  - Contents are retained.
  - A bank never enters standby while it is the latched target in WAKE or RESP.

## Timing
- Reset values: state IDLE, `done`=0, `rdata`=0, `bank_asleep`=0, all idle counters 0, wake counter 0.
- Awake bank: request first seen at edge N → access at edge N; `done` high during cycle N+1. Single-cycle latency; peak throughput one access per 2 cycles.
- Sleeping bank: `done` high during cycle N+1+`WAKE_CYCLES`.
- The master may deassert `ren`/`wen` in the cycle after `done`. If they are still high in IDLE, a new access starts.
- `bank_asleep` changes on the edge the idle counter saturates; it is visible the next cycle.
- Reset asserted mid-operation: FSM returns to IDLE immediately and no `done` is issued. A write is committed only if its access edge preceded reset assertion. Memory contents are otherwise undefined across reset (SPRAM retains).

## Test plan
- Write 0xDEADBEEF, mask 0xF, to 0xF0000000, then read 0xF0000000 → `done` one cycle after each request, `rdata`=0xDEADBEEF.
- Write 0x11223344 to 0xF001FFFC, then write 0xAABBCCDD with mask 0x5 → read 0x11BB33DD. Address 0xF0020000 → `active`=0, no `done` for 10 cycles.
- Write 0x1 to 0xF0000000 and 0x2 to 0xF0010000 → reads return 0x1 and 0x2 (bank 0 and bank 1 are distinct).
- `IDLE_CYCLES`=4, `WAKE_CYCLES`=3: access bank 1, wait 5 cycles → `bank_asleep`[1]=1. Read bank 1 → `done` 4 cycles after request, data intact.
- `ren`=`wen`=1 to 0xF0000008 with wdata 0x55 → treated as write, `rdata` unchanged; a subsequent read returns 0x55.
- Assert `rst_n`=0 during WAKE → `done` stays 0, all outputs take reset values. After release, a read returns the pre-reset contents.

Source files
------------

// File: rtl/memory_spram_banked.sv
// memory_spram_banked
//   NUM_BANKS x 16K-word, 32-bit SPRAM region on the CPU data bus. Each bank
//   pairs two 16-bit SPRAM cells (MSB/LSB halves). A small access FSM gives
//   fixed done timing: one cycle for an awake bank, 1+WAKE_CYCLES for a bank
//   that has to come out of retention standby first. Banks left idle for
//   IDLE_CYCLES cycles drop into standby on their own (contents retained).
//
// Ports
//   clk, rst_n      : clock (rising edge), async active-low reset
//   addr_i          : byte address, [1:0] ignored
//   wdata_i/wmask_i : write data / byte enables
//   wen_i / ren_i   : request strobes, held by the master until done_o
//   rdata_o         : last completed read data
//   done_o          : one-cycle completion pulse
//   active_o        : addr_i falls inside this block's region (combinational)
//   bank_asleep_o   : per-bank standby state

// Behavioural stand-in for one SB_SPRAM256KA cell (16K x 16, nibble write
// mask, registered read port). Port names follow the vendor cell so the
// instance can be swapped for the hard primitive.
module memory_spram_banked_prim (
  input  logic        CLOCK,
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);
  logic [15:0] mem [0:16383];
  logic        en;

  assign en = CHIPSELECT & ~STANDBY & ~SLEEP & POWEROFF;

  always_ff @(posedge CLOCK) begin
    if (en) begin
      if (WREN) begin
        for (int n = 0; n < 4; n++)
          if (MASKWREN[n]) mem[ADDRESS][4*n +: 4] <= DATAIN[4*n +: 4];
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end
endmodule

// One 32-bit bank: two cells plus its own idle counter / standby flag.
module memory_spram_banked_lane #(
  parameter int unsigned IDLE_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [13:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  wmask_i,
  input  logic        wake_i,   // leave standby this edge
  input  logic        hold_i,   // bank is the FSM's latched target
  output logic        asleep_o,
  output logic [31:0] dout_o
);
  logic       asleep_q;
  logic [3:0] mask_hi, mask_lo;

  if (IDLE_CYCLES > 0) begin : g_pm
    localparam int unsigned CW = $clog2(IDLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(IDLE_CYCLES);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          asleep_d;

    always_comb begin
      cnt_d = cnt_q;
      if (cs_i)              cnt_d = '0;
      else if (cnt_q != SAT) cnt_d = cnt_q + 1'b1;
      // Wake wins; otherwise sleep on the saturating edge unless the FSM
      // is working on this bank.
      asleep_d = asleep_q;
      if (wake_i)                        asleep_d = 1'b0;
      else if (cnt_d == SAT && !hold_i)  asleep_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q    <= '0;
        asleep_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        asleep_q <= asleep_d;
      end
    end
  end else begin : g_nopm
    logic unused_pm;
    assign unused_pm = wake_i ^ hold_i;
    assign asleep_q  = 1'b0;
  end

  assign asleep_o = asleep_q;
  assign mask_hi  = {wmask_i[3], wmask_i[3], wmask_i[2], wmask_i[2]};
  assign mask_lo  = {wmask_i[1], wmask_i[1], wmask_i[0], wmask_i[0]};

  memory_spram_banked_prim u_hi (
    .CLOCK(clk), .ADDRESS(addr_i), .DATAIN(wdata_i[31:16]), .MASKWREN(mask_hi),
    .WREN(we_i), .CHIPSELECT(cs_i), .STANDBY(asleep_q), .SLEEP(1'b0),
    .POWEROFF(1'b1), .DATAOUT(dout_o[31:16])
  );

  memory_spram_banked_prim u_lo (
    .CLOCK(clk), .ADDRESS(addr_i), .DATAIN(wdata_i[15:0]), .MASKWREN(mask_lo),
    .WREN(we_i), .CHIPSELECT(cs_i), .STANDBY(asleep_q), .SLEEP(1'b0),
    .POWEROFF(1'b1), .DATAOUT(dout_o[15:0])
  );
endmodule

module memory_spram_banked #(
  parameter logic [31:0] BASE_ADDRESS = 32'hF000_0000,
  parameter int unsigned NUM_BANKS    = 2,
  parameter int unsigned BANK_WORDS   = 16384,
  parameter int unsigned IDLE_CYCLES  = 64,
  parameter int unsigned WAKE_CYCLES  = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          addr_i,
  input  logic [31:0]          wdata_i,
  input  logic [3:0]           wmask_i,
  input  logic                 wen_i,
  input  logic                 ren_i,
  output logic [31:0]          rdata_o,
  output logic                 done_o,
  output logic                 active_o,
  output logic [NUM_BANKS-1:0] bank_asleep_o
);
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned BW     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int unsigned WCW    = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [31:0] REGION = 32'(NUM_BANKS * BANK_WORDS * 4);

  typedef enum logic [1:0] {S_IDLE, S_WAKE, S_RESP} state_e;

  typedef struct packed {
    logic          go;
    logic          wr;
    logic [BW-1:0] bank;
  } acc_t;

  state_e                         state_q;
  logic [BW-1:0]                  bank_q;
  logic                           wr_q;
  logic [WCW-1:0]                 wake_cnt_q;
  logic                           done_q;
  logic [31:0]                    rdata_q;

  logic [31:0]                    off;
  logic [BW-1:0]                  bank_sel;
  logic                           req;
  acc_t                           acc;
  logic [NUM_BANKS-1:0]           cs, we, wake_start, hold, asleep;
  logic [NUM_BANKS-1:0][31:0]     bank_dout;

  // Addresses below the base wrap to a huge offset, so one compare covers
  // both ends of the region.
  assign off      = addr_i - BASE_ADDRESS;
  assign active_o = off < REGION;
  assign bank_sel = off[2+ADDR_W +: BW];
  assign req      = active_o & (ren_i | wen_i);

  always_comb begin
    acc        = '0;
    wake_start = '0;
    if (state_q == S_IDLE && req) begin
      if (asleep[bank_sel]) begin
        wake_start[bank_sel] = 1'b1;
      end else begin
        acc.go   = 1'b1;
        acc.wr   = wen_i;
        acc.bank = bank_sel;
      end
    end else if (state_q == S_WAKE && wake_cnt_q == '0) begin
      acc.go   = 1'b1;
      acc.wr   = wr_q;
      acc.bank = bank_q;
    end
  end

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      cs[b]   = acc.go && (acc.bank == BW'(b));
      we[b]   = cs[b] && acc.wr;
      hold[b] = (state_q != S_IDLE) && (bank_q == BW'(b));
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    memory_spram_banked_lane #(.IDLE_CYCLES(IDLE_CYCLES)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .cs_i     (cs[b]),
      .we_i     (we[b]),
      .addr_i   (off[2 +: ADDR_W]),
      .wdata_i  (wdata_i),
      .wmask_i  (wmask_i),
      .wake_i   (wake_start[b]),
      .hold_i   (hold[b]),
      .asleep_o (asleep[b]),
      .dout_o   (bank_dout[b])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bank_q     <= '0;
      wr_q       <= 1'b0;
      wake_cnt_q <= '0;
      done_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (req) begin
          bank_q <= bank_sel;
          wr_q   <= wen_i;
          if (asleep[bank_sel]) begin
            wake_cnt_q <= WCW'(WAKE_CYCLES - 1);
            state_q    <= S_WAKE;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_RESP;
          end
        end
        S_WAKE: if (wake_cnt_q == '0) begin
          done_q  <= 1'b1;
          state_q <= S_RESP;
        end else begin
          wake_cnt_q <= wake_cnt_q - 1'b1;
        end
        S_RESP: begin
          if (!wr_q) rdata_q <= bank_dout[bank_q];
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Cell read port is already registered, so during RESP the fresh word is
  // forwarded straight out; rdata_q holds it afterwards.
  assign rdata_o       = (state_q == S_RESP && !wr_q) ? bank_dout[bank_q] : rdata_q;
  assign done_o        = done_q;
  assign bank_asleep_o = asleep;
endmodule

// File: tb/tb_memory_spram_banked.sv
module tb_memory_spram_banked;
  localparam int IDLE = 4;
  localparam int WAKE = 3;
  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] addr = '0, wdata = '0;
  logic [3:0]  wmask = '0;
  logic        wen = 1'b0, ren = 1'b0;
  logic [31:0] rdata;
  logic        done, active;
  logic [1:0]  bank_asleep;

  memory_spram_banked #(
    .BASE_ADDRESS(BASE), .NUM_BANKS(2), .BANK_WORDS(16384),
    .IDLE_CYCLES(IDLE), .WAKE_CYCLES(WAKE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr_i(addr), .wdata_i(wdata), .wmask_i(wmask),
    .wen_i(wen), .ren_i(ren), .rdata_o(rdata), .done_o(done),
    .active_o(active), .bank_asleep_o(bank_asleep)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] rdata; int cyc; } exp_t;
  exp_t        sb_q[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] mem_m [int];
  logic [31:0] rdata_m = '0;
  int          last_acc [2];
  int          op_id = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) chk("spurious_done", 32'(done), 32'd0);
      else begin
        e = sb_q.pop_front();
        chk($sformatf("op%0d_done_cyc", e.id), cyc, e.cyc);
        chk($sformatf("op%0d_rdata", e.id), rdata, e.rdata);
      end
    end
  end

  // Called just after a negedge with the FSM idle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic w, input logic r);
    int n, b, lat, wi;
    exp_t e;
    logic got;
    logic [31:0] cur;
    addr = a; wdata = d; wmask = m; wen = w; ren = r;
    wi  = int'((a - BASE) >> 2);
    b   = wi / 16384;
    n   = cyc + 1;                          // edge that samples the request
    lat = (n - last_acc[b] > IDLE) ? WAKE : 0;
    last_acc[b] = n + lat;
    if (w) begin
      cur = mem_m.exists(wi) ? mem_m[wi] : 32'h0;
      for (int i = 0; i < 4; i++) if (m[i]) cur[8*i +: 8] = d[8*i +: 8];
      mem_m[wi] = cur;
    end else begin
      rdata_m = mem_m.exists(wi) ? mem_m[wi] : 32'h0;
    end
    e.id = op_id; e.rdata = rdata_m; e.cyc = n + lat;
    op_id++;
    sb_q.push_back(e);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (done) got = 1'b1;
    end
    wen = 1'b0; ren = 1'b0;
    if (!got) begin
      chk($sformatf("op%0d_timeout", e.id), 32'(done), 32'd1);
      void'(sb_q.pop_back());
    end
    @(negedge clk);
  endtask

  logic [31:0] pool [6] = '{32'hF000_0010, 32'hF000_0014, 32'hF000_4000,
                            32'hF001_0020, 32'hF001_FFF8, 32'hF001_8000};

  initial begin
    int idx, kind;
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_asleep", 32'(bank_asleep), 32'd0);
    addr = BASE;         #1 chk("active_base", 32'(active), 32'd1);
    addr = 32'hF001FFFC; #1 chk("active_top", 32'(active), 32'd1);
    addr = 32'hF002_0000;#1 chk("active_past", 32'(active), 32'd0);
    addr = 32'hEFFF_FFFC;#1 chk("active_below", 32'(active), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    last_acc[0] = cyc; last_acc[1] = cyc;

    do_op(32'hF000_0000, 32'hDEADBEEF, 4'hF, 1, 0);
    do_op(32'hF000_0000, 32'h0, 4'h0, 0, 1);

    do_op(32'hF001_FFFC, 32'h11223344, 4'hF, 1, 0);
    do_op(32'hF001_FFFC, 32'hAABBCCDD, 4'h5, 1, 0);
    do_op(32'hF001_FFFC, 32'h0, 4'h0, 0, 1);
    chk("mask_merge", rdata, 32'h11BB33DD);

    addr = 32'hF002_0000; ren = 1'b1; wen = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("inactive_no_done", 32'(done), 32'd0);
    end
    ren = 1'b0; wen = 1'b0;
    @(negedge clk);

    do_op(32'hF000_0000, 32'h1, 4'hF, 1, 0);
    do_op(32'hF001_0000, 32'h2, 4'hF, 1, 0);
    do_op(32'hF000_0000, 32'h0, 4'h0, 0, 1);
    do_op(32'hF001_0000, 32'h0, 4'h0, 0, 1);

    repeat (8) @(negedge clk);
    chk("asleep_b1", 32'(bank_asleep[1]), 32'd1);
    do_op(32'hF001_0000, 32'h0, 4'h0, 0, 1);   // wake path

    do_op(32'hF000_0008, 32'h55, 4'hF, 1, 1);  // both strobes: write
    do_op(32'hF000_0008, 32'hFFFF_FFFF, 4'h0, 1, 0);
    do_op(32'hF000_0008, 32'h0, 4'h0, 0, 1);

    // Reset in the middle of a wake.
    repeat (8) @(negedge clk);
    chk("asleep_b0", 32'(bank_asleep[0]), 32'd1);
    addr = 32'hF000_0000; ren = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_rdata", rdata, 32'd0);
    chk("midrst_asleep", 32'(bank_asleep), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_done_hold", 32'(done), 32'd0);
    ren = 1'b0;
    rst_n = 1'b1;
    last_acc[0] = cyc; last_acc[1] = cyc;
    rdata_m = '0;
    do_op(32'hF000_0008, 32'h0, 4'h0, 0, 1);
    do_op(32'hF000_0000, 32'h0, 4'h0, 0, 1);
    do_op(32'hF001_FFFC, 32'h0, 4'h0, 0, 1);

    for (int i = 0; i < 6; i++) do_op(pool[i], $urandom, 4'hF, 1, 0);
    for (int i = 0; i < 24; i++) begin
      idx  = $urandom_range(0, 5);
      kind = $urandom_range(0, 2);
      if (kind == 0) do_op(pool[idx], 32'h0, 4'h0, 0, 1);
      else           do_op(pool[idx], $urandom, 4'($urandom_range(0, 15)), 1, kind == 2);
      repeat ($urandom_range(0, 6)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule
